// File: rtl/ethernet_descriptor_ram_dp.sv
// Dual-port descriptor RAM with byte enables, 1-cycle read latency and an optional
// zero-fill sweep enabled by the DESCRIPTOR_RAM_CLEAR_EN macro.
module ethernet_descriptor_ram_dp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   writedata,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest,
    input  logic [ADDR_WIDTH-1:0]   address2,
    input  logic [DATA_WIDTH/8-1:0] byteenable2,
    input  logic                    chipselect2,
    input  logic                    read2,
    input  logic                    write2,
    input  logic [DATA_WIDTH-1:0]   writedata2,
    output logic [DATA_WIDTH-1:0]   readdata2,
    output logic                    readdatavalid2,
    output logic                    waitrequest2,
    input  logic                    clear,
    output logic                    clear_busy
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  sweep_we;
    logic [ADDR_WIDTH-1:0] sweep_addr;

`ifdef DESCRIPTOR_RAM_CLEAR_EN
    typedef enum logic {INIT, READY} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A clear arriving during INIT is deliberately not decoded, so the sweep never restarts.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            INIT: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == '1)
                    state_nxt = READY;
            end
            READY: begin
                if (clear) begin
                    state_nxt = INIT;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    assign waitrequest  = (state == INIT);
    assign waitrequest2 = (state == INIT);
    assign clear_busy   = (state == INIT);
    assign sweep_we     = (state == INIT);
    assign sweep_addr   = cnt;
`else
    logic unused_clear;
    assign unused_clear = clear;

    assign waitrequest  = 1'b0;
    assign waitrequest2 = 1'b0;
    assign clear_busy   = 1'b0;
    assign sweep_we     = 1'b0;
    assign sweep_addr   = '0;
`endif

    // Stage p0: command acceptance; a combined read+write is treated as a write only.
    logic wr_en_p0, rd_en_p0, wr_en2_p0, rd_en2_p0;

    assign wr_en_p0  = chipselect  & ~waitrequest  & write;
    assign rd_en_p0  = chipselect  & ~waitrequest  & read  & ~write;
    assign wr_en2_p0 = chipselect2 & ~waitrequest2 & write2;
    assign rd_en2_p0 = chipselect2 & ~waitrequest2 & read2 & ~write2;

    // Port 2 lanes are applied first so port 1 wins any byte both ports enable.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[sweep_addr] <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (wr_en2_p0 && byteenable2[b])
                    mem[address2][b*8 +: 8] <= writedata2[b*8 +: 8];
                if (wr_en_p0 && byteenable[b])
                    mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
            end
        end
    end

    // Stage p1: registered read data; sampled before this edge's writes land (read-before-write).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata       <= '0;
            readdatavalid  <= 1'b0;
            readdata2      <= '0;
            readdatavalid2 <= 1'b0;
        end else begin
            readdatavalid  <= rd_en_p0;
            readdatavalid2 <= rd_en2_p0;
            if (rd_en_p0)
                readdata <= mem[address];
            if (rd_en2_p0)
                readdata2 <= mem[address2];
        end
    end

endmodule
